// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel arbiter in front of one single-port synchronous memory, read data routed back by an ID pipeline.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH-1:0]          wen_i,
    input  logic [N_CH*DATA_W/8-1:0] stb_i,
    input  logic [N_CH*ADDR_W-1:0]   addr_i,
    input  logic [N_CH*DATA_W-1:0]   wdata_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic [N_CH-1:0]          stall_o,
    output logic [N_CH-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     mem_en_o,
    output logic                     mem_wen_o,
    output logic [DATA_W/8-1:0]      mem_stb_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [DATA_W-1:0]        mem_rdata_i
);
    localparam int STB_W = DATA_W / 8;
    localparam int IDW   = N_CH > 1 ? $clog2(N_CH) : 1;

    logic [IDW-1:0]     win;
    logic               found;
    logic               any;
    int                 idx;
    logic [MEM_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [MEM_LAT];

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr;

    // Move priority to the channel after the most recent winner
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            ptr <= '0;
        else if (any)
            ptr <= (win == IDW'(N_CH - 1)) ? '0 : win + 1'b1;
`endif

    // Pick the first requesting channel in priority order; win stays 0 when nobody asks
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = (int'(ptr) + i) % N_CH;
`else
            idx = i;
`endif
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign any         = found & ~rst_i;
    assign stall_o     = rst_i ? '0 : req_i & ~gnt_o;
    assign mem_en_o    = any;
    assign mem_wen_o   = any & wen_i[win];
    assign mem_stb_o   = any ? stb_i[int'(win)*STB_W +: STB_W] : '0;
    assign mem_addr_o  = addr_i[int'(win)*ADDR_W +: ADDR_W];
    assign mem_wdata_o = wdata_i[int'(win)*DATA_W +: DATA_W];
    assign rdata_o     = mem_rdata_i;

    // Decode winner and returning tag into one-hot grant / read-valid vectors
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            gnt_o[k]    = any && (win == IDW'(k));
            rvalid_o[k] = tag_vld[MEM_LAT-1] && !rst_i && (tag_id[MEM_LAT-1] == IDW'(k));
        end
    end

    // Track issued reads through the memory latency; writes enter as bubbles
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            tag_vld <= '0;
            for (int s = 0; s < MEM_LAT; s++)
                tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= any & ~wen_i[win];
            tag_id[0]  <= win;
            for (int s = 1; s < MEM_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a read-return scoreboard for mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_arbiter;
    typedef struct {
        int          ch;
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   errs = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic [1:0]  req_a = '0, wen_a = '0, gnt_a, stall_a, rvalid_a;
    logic [7:0]  stb_a = '0;
    logic [63:0] addr_a = '0, wdata_a = '0;
    logic [31:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
    logic        men_a, mwen_a;
    logic [3:0]  mstb_a;
    logic [31:0] mem_a [256];

    logic [1:0]  req_b = '0, wen_b = '0, gnt_b, stall_b, rvalid_b;
    logic [7:0]  stb_b = '0;
    logic [63:0] addr_b = '0, wdata_b = '0;
    logic [31:0] rdata_b, maddr_b, mwdata_b;
    logic        men_b, mwen_b;
    logic [3:0]  mstb_b;
    logic [31:0] mem_b [256];
    logic [31:0] rd_b [3];

    mem_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .wen_i(wen_a), .stb_i(stb_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .stall_o(stall_a),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .mem_en_o(men_a), .mem_wen_o(mwen_a),
        .mem_stb_o(mstb_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a)
    );

    mem_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .wen_i(wen_b), .stb_i(stb_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .stall_o(stall_b),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .mem_en_o(men_b), .mem_wen_o(mwen_b),
        .mem_stb_o(mstb_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_rdata_i(rd_b[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: contents preloaded while reset is held, byte-strobed writes, registered reads
    always @(posedge clk) begin
        if (rst) begin
            mem_a[4]  <= 32'h11111111;
            mem_a[8]  <= 32'h22222222;
            mem_a[16] <= 32'hDEADBEEF;
            mem_a[32] <= 32'hAAAAAAAA;
            mem_b[0]  <= 32'hB0B0B0B0;
            mem_b[1]  <= 32'hB4B4B4B4;
            mem_b[2]  <= 32'hB8B8B8B8;
        end else begin
            if (men_a && mwen_a) begin
                for (int b = 0; b < 4; b++)
                    if (mstb_a[b]) mem_a[maddr_a[9:2]][8*b +: 8] <= mwdata_a[8*b +: 8];
            end else if (men_a) begin
                mrdata_a <= mem_a[maddr_a[9:2]];
            end
            if (men_b && !mwen_b) rd_b[0] <= mem_b[maddr_b[9:2]];
        end
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drv_a(input int ch, input logic w, input logic [3:0] s, input logic [31:0] ad, input logic [31:0] wd);
        wen_a[ch] = w;
        stb_a[ch*4 +: 4] = s;
        addr_a[ch*32 +: 32] = ad;
        wdata_a[ch*32 +: 32] = wd;
    endtask

    task automatic drv_b(input int ch, input logic [31:0] ad);
        wen_b[ch] = 1'b0;
        stb_b[ch*4 +: 4] = 4'hF;
        addr_b[ch*32 +: 32] = ad;
    endtask

    task automatic push_a(input int ch, input logic [31:0] d);
        qa.push_back('{ch: ch, d: d, due: cyc + 1});
    endtask

    task automatic push_b(input int ch, input logic [31:0] d);
        qb.push_back('{ch: ch, d: d, due: cyc + 3});
    endtask

    // Monitor for the MEM_LAT=1 instance: every rvalid must match the oldest expected read
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        while (qa.size() > 0 && qa[0].due < cyc) begin
            e = qa.pop_front();
            nchk++;
            errs++;
            $display("FAIL rv_a_missing: got no rvalid, expected ch%0d data %h at cycle %0d", e.ch, e.d, e.due);
        end
        if (rvalid_a != 2'b00) begin
            if (qa.size() == 0) begin
                chk("rv_a_unexpected", {30'd0, rvalid_a}, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("rv_a_ch", {30'd0, rvalid_a}, 32'd1 << e.ch);
                chk("rv_a_data", rdata_a, e.d);
                chk("rv_a_cycle", cyc, e.due);
            end
        end
    end

    // Monitor for the MEM_LAT=3 instance
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        while (qb.size() > 0 && qb[0].due < cyc) begin
            e = qb.pop_front();
            nchk++;
            errs++;
            $display("FAIL rv_b_missing: got no rvalid, expected ch%0d data %h at cycle %0d", e.ch, e.d, e.due);
        end
        if (rvalid_b != 2'b00) begin
            if (qb.size() == 0) begin
                chk("rv_b_unexpected", {30'd0, rvalid_b}, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("rv_b_ch", {30'd0, rvalid_b}, 32'd1 << e.ch);
                chk("rv_b_data", rdata_b, e.d);
                chk("rv_b_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, errors=%0d", errs);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] eg;
        logic [31:0] bdat [3];
        bdat[0] = 32'hB0B0B0B0;
        bdat[1] = 32'hB4B4B4B4;
        bdat[2] = 32'hB8B8B8B8;
        repeat (2) @(negedge clk);
        // Reset holds everything quiet even with both channels requesting
        req_a = 2'b11;
        drv_a(0, 1'b0, 4'hF, 32'h10, 32'h0);
        drv_a(1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1;
        chk("rst_gnt", {30'd0, gnt_a}, 32'd0);
        chk("rst_stall", {30'd0, stall_a}, 32'd0);
        chk("rst_men", {31'd0, men_a}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid_a}, 32'd0);
        // Release: grant in the first cycle, ch0 wins, ch1 stalls
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_gnt", {30'd0, gnt_a}, 32'd1);
        chk("rel_stall", {30'd0, stall_a}, 32'd2);
        chk("rel_men", {31'd0, men_a}, 32'd1);
        chk("rel_addr", maddr_a, 32'h10);
        push_a(0, 32'h11111111);
        @(negedge clk);
        req_a = 2'b10;
        #1;
        chk("ch1_gnt", {30'd0, gnt_a}, 32'd2);
        chk("ch1_stall", {30'd0, stall_a}, 32'd0);
        chk("ch1_addr", maddr_a, 32'h20);
        push_a(1, 32'h22222222);
        // Byte-strobed write then read-back of the merged word
        @(negedge clk);
        req_a = 2'b01;
        drv_a(0, 1'b1, 4'b0011, 32'h80, 32'h12345678);
        #1;
        chk("wr_gnt", {30'd0, gnt_a}, 32'd1);
        chk("wr_wen", {31'd0, mwen_a}, 32'd1);
        chk("wr_stb", {28'd0, mstb_a}, 32'd3);
        chk("wr_addr", maddr_a, 32'h80);
        chk("wr_wdata", mwdata_a, 32'h12345678);
        @(negedge clk);
        drv_a(0, 1'b0, 4'hF, 32'h80, 32'h0);
        #1;
        chk("rd80_wen", {31'd0, mwen_a}, 32'd0);
        push_a(0, 32'hAAAA5678);
        // Single ch1 read
        @(negedge clk);
        req_a = 2'b10;
        drv_a(1, 1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        chk("rd40_gnt", {30'd0, gnt_a}, 32'd2);
        chk("rd40_stall", {30'd0, stall_a}, 32'd0);
        push_a(1, 32'hDEADBEEF);
        // Idle: write enable and strobes of a non-requesting channel must not leak out
        @(negedge clk);
        req_a = 2'b00;
        drv_a(0, 1'b1, 4'hF, 32'h1234, 32'h55);
        #1;
        chk("idle_gnt", {30'd0, gnt_a}, 32'd0);
        chk("idle_men", {31'd0, men_a}, 32'd0);
        chk("idle_wen", {31'd0, mwen_a}, 32'd0);
        chk("idle_stb", {28'd0, mstb_a}, 32'd0);
        chk("idle_addr", maddr_a, 32'h1234);
        // Both channels held for six cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                drv_a(0, 1'b0, 4'hF, 32'h10, 32'h0);
                drv_a(1, 1'b0, 4'hF, 32'h20, 32'h0);
                req_a = 2'b11;
            end
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            chk("both_gnt", {30'd0, gnt_a}, {30'd0, eg});
            chk("both_stall", {30'd0, stall_a}, {30'd0, ~eg});
            if (eg == 2'b01) push_a(0, 32'h11111111);
            else push_a(1, 32'h22222222);
        end
        @(negedge clk);
        req_a = 2'b00;
        repeat (3) @(negedge clk);
        // MEM_LAT=3: three back-to-back ch1 reads
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_b = 2'b10;
            drv_b(1, 32'(i * 4));
            #1;
            chk("lat3_gnt", {30'd0, gnt_b}, 32'd2);
            push_b(1, bdat[i]);
        end
        @(negedge clk);
        req_b = 2'b00;
        repeat (5) @(negedge clk);
        // Reads in flight when reset hits must never return
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_b = 2'b10;
            drv_b(1, 32'(i * 4));
            #1;
            chk("drop_gnt", {30'd0, gnt_b}, 32'd2);
        end
        @(negedge clk);
        drv_b(1, 32'h8);
        rst = 1'b1;
        #1;
        chk("drop_rst_gnt", {30'd0, gnt_b}, 32'd0);
        chk("drop_rst_men", {31'd0, men_b}, 32'd0);
        chk("drop_rst_stall", {30'd0, stall_b}, 32'd0);
        chk("drop_rst_rvalid", {30'd0, rvalid_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_b = 2'b01;
        drv_b(0, 32'h8);
        #1;
        chk("post_rst_gnt", {30'd0, gnt_b}, 32'd1);
        push_b(0, 32'hB8B8B8B8);
        @(negedge clk);
        req_b = 2'b00;
        repeat (6) @(negedge clk);
        chk("qa_empty", qa.size(), 32'd0);
        chk("qb_empty", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
